// File: rtl/lsic_pkg.sv
// Shared constants and types for the lsic_n interrupt controller.
package lsic_pkg;

    // Register window offsets (word offsets inside the 16-word block)
    localparam logic [3:0] OFF_DISA   = 4'h0;
    localparam logic [3:0] OFF_PEND   = 4'h4;
    localparam logic [3:0] OFF_EDGE   = 4'h8;
    localparam logic [3:0] OFF_CLAIM  = 4'hC;
    localparam logic [3:0] OFF_IPL    = 4'hD;
    localparam logic [3:0] OFF_BAD    = 4'hE;
    localparam logic [3:0] OFF_STATUS = 4'hF;

    // Avalon response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Claim id is sized for the largest configuration (128 sources)
    localparam int CLAIM_IDW = 7;

    typedef struct packed {
        logic                 valid;
        logic [CLAIM_IDW-1:0] id;
    } claim_t;

endpackage

// File: rtl/lsic_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module lsic_prio_enc #(
    parameter int N   = 64,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    output logic           valid,
    output logic [IDW-1:0] id
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/lsic_n.sv
// lsic_n: Avalon-MM interrupt controller with per-source edge/level mode,
// claim/complete handshake, priority threshold and bad-address latch.
module lsic_n
    import lsic_pkg::*;
#(
    parameter int          NUM_IRQS  = 64,
    parameter logic [29:0] BASE_WORD = 30'h3E00C000,
    parameter int          IDW       = $clog2(NUM_IRQS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQS-1:0] irqs,
    input  logic [31:0]         badAddr,
    input  logic                badAddrValid,
    output logic                badAddrAck,
    output logic                cpu_irq,
    output logic                cpu_buserror,
    input  logic [4:0]          bus_burstcount,
    input  logic [31:0]         bus_writedata,
    input  logic [29:0]         bus_address,
    input  logic                bus_write,
    input  logic                bus_read,
    input  logic [3:0]          bus_byteenable,
    output logic                s_waitrequest,
    output logic [31:0]         s_readdata,
    output logic                s_readdatavalid,
    output logic                s_writeresponsevalid,
    output logic [1:0]          s_response
);

    localparam int W = NUM_IRQS / 32;

    // State
    logic [NUM_IRQS-1:0] disa_q, disa_d;
    logic [NUM_IRQS-1:0] pend_q, pend_d;
    logic [NUM_IRQS-1:0] edge_mode_q, edge_mode_d;
    logic [NUM_IRQS-1:0] irqs_q, irqs_d;
    logic [IDW:0]        ipl_q, ipl_d;
    claim_t              claim_q, claim_d;
    logic [32:0]         bad_q, bad_d;
    logic                ack_q, ack_d;
    logic                rvalid_q, rvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;

    // Decode helpers
    logic                hit, rd_acc, wr_acc, err, ok_rd, ok_wr, bank_bad;
    logic [3:0]          off;
    logic [1:0]          grp, bidx;
    logic [NUM_IRQS-1:0] set_vec, elig;
    logic                enc_valid;
    logic [IDW-1:0]      enc_id;
    logic                unused_byteenable;

    assign unused_byteenable = ^bus_byteenable;

    // Bus decode, register reads/writes, pending update and bad-address latch
    always_comb begin
        disa_d      = disa_q;
        pend_d      = pend_q;
        edge_mode_d = edge_mode_q;
        irqs_d      = irqs;
        ipl_d       = ipl_q;
        bad_d       = bad_q;
        ack_d       = badAddrValid;
        rdata_d     = 32'h0;

        hit      = (bus_address[29:4] == BASE_WORD[29:4]) && (bus_read || bus_write);
        rd_acc   = hit && bus_read;
        wr_acc   = hit && !bus_read && bus_write;
        off      = bus_address[3:0];
        grp      = off[3:2];
        bidx     = off[1:0];
        bank_bad = (grp != OFF_CLAIM[3:2]) && (int'(bidx) >= W);
        err      = (bus_burstcount != 5'd1) || bank_bad || (wr_acc && off == OFF_STATUS);
        ok_rd    = rd_acc && !err;
        ok_wr    = wr_acc && !err;

        rvalid_d = rd_acc;
        wvalid_d = wr_acc;
        resp_d   = (hit && err) ? RESP_DECERR : RESP_OKAY;

        // Register read mux
        if (ok_rd) begin
            if (grp == OFF_CLAIM[3:2]) begin
                case (off)
                    OFF_CLAIM:  rdata_d = {claim_q.valid, 24'd0, claim_q.id};
                    OFF_IPL:    rdata_d = 32'(ipl_q);
                    OFF_BAD:    rdata_d = bad_q[31:0];
                    default:    rdata_d = {claim_q.valid, bad_q[32], 30'd0};
                endcase
            end else begin
                for (int w = 0; w < W; w++) begin
                    if (bidx == 2'(w)) begin
                        if (grp == OFF_DISA[3:2])      rdata_d = disa_q[w*32 +: 32];
                        else if (grp == OFF_PEND[3:2]) rdata_d = pend_q[w*32 +: 32];
                        else                           rdata_d = edge_mode_q[w*32 +: 32];
                    end
                end
            end
        end

        // Clear terms: claim read retires the claimed source
        if (ok_rd && off == OFF_CLAIM && claim_q.valid) begin
            for (int i = 0; i < NUM_IRQS; i++) begin
                if (claim_q.id == CLAIM_IDW'(i)) pend_d[i] = 1'b0;
            end
        end

        // Register writes (bank words, completion, threshold)
        if (ok_wr) begin
            if (grp == OFF_CLAIM[3:2]) begin
                if (off == OFF_CLAIM) begin
                    for (int i = 0; i < NUM_IRQS; i++) begin
                        if (bus_writedata[IDW-1:0] == IDW'(i)) pend_d[i] = 1'b0;
                    end
                end else if (off == OFF_IPL) begin
                    if (bus_writedata > 32'(NUM_IRQS)) ipl_d = (IDW+1)'(NUM_IRQS);
                    else                               ipl_d = bus_writedata[IDW:0];
                end
            end else begin
                for (int w = 0; w < W; w++) begin
                    if (bidx == 2'(w)) begin
                        if (grp == OFF_DISA[3:2]) begin
                            disa_d[w*32 +: 32] = bus_writedata;
                        end else if (grp == OFF_PEND[3:2]) begin
                            if (bus_writedata == 32'h0) pend_d[w*32 +: 32] = 32'h0;
                            else pend_d[w*32 +: 32] = pend_q[w*32 +: 32] | bus_writedata;
                        end else begin
                            edge_mode_d[w*32 +: 32] = bus_writedata;
                        end
                    end
                end
            end
        end

        // Set terms win over any clear in the same cycle
        set_vec = (~edge_mode_q & irqs) | (edge_mode_q & irqs & ~irqs_q);
        pend_d  = pend_d | set_vec;

        // Capture beats a clearing read; the read still returns the old value
        if (ok_rd && off == OFF_BAD) bad_d = 33'h0;
        if (badAddrValid)            bad_d = {1'b1, badAddr};
    end

    // Eligible sources: pending, enabled and below the threshold
    always_comb begin
        for (int i = 0; i < NUM_IRQS; i++) begin
            elig[i] = pend_q[i] && !disa_q[i] && ((IDW+1)'(i) < ipl_q);
        end
    end

    lsic_prio_enc #(
        .N   (NUM_IRQS),
        .IDW (IDW)
    ) u_prio_enc (
        .req   (elig),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // Pack the encoder result into the registered claim
    always_comb begin
        claim_d.valid = enc_valid;
        claim_d.id    = CLAIM_IDW'(enc_id);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            disa_q      <= '0;
            pend_q      <= '0;
            edge_mode_q <= '0;
            irqs_q      <= '0;
            ipl_q       <= (IDW+1)'(NUM_IRQS);
            claim_q     <= '0;
            bad_q       <= '0;
            ack_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            wvalid_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            disa_q      <= disa_d;
            pend_q      <= pend_d;
            edge_mode_q <= edge_mode_d;
            irqs_q      <= irqs_d;
            ipl_q       <= ipl_d;
            claim_q     <= claim_d;
            bad_q       <= bad_d;
            ack_q       <= ack_d;
            rvalid_q    <= rvalid_d;
            wvalid_q    <= wvalid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    assign badAddrAck           = ack_q;
    assign cpu_irq              = claim_q.valid;
    assign cpu_buserror         = bad_q[32];
    assign s_waitrequest        = 1'b0;
    assign s_readdata           = rdata_q;
    assign s_readdatavalid      = rvalid_q;
    assign s_writeresponsevalid = wvalid_q;
    assign s_response           = resp_q;

endmodule

// File: tb/tb_lsic_n.sv
// Directed bench for lsic_n (NUM_IRQS = 64).
module tb_lsic_n;

    localparam int          N    = 64;
    localparam logic [29:0] BASE = 30'h3E00C000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irqs = '0;
    logic [31:0]   badAddr = '0;
    logic          badAddrValid = 1'b0;
    logic          badAddrAck, cpu_irq, cpu_buserror;
    logic [4:0]    bus_burstcount = 5'd1;
    logic [31:0]   bus_writedata = '0;
    logic [29:0]   bus_address = '0;
    logic          bus_write = 1'b0, bus_read = 1'b0;
    logic [3:0]    bus_byteenable = 4'hF;
    logic          s_waitrequest, s_readdatavalid, s_writeresponsevalid;
    logic [31:0]   s_readdata;
    logic [1:0]    s_response;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsic_n #(.NUM_IRQS(N), .BASE_WORD(BASE)) dut (
        .clk(clk), .rst(rst), .irqs(irqs),
        .badAddr(badAddr), .badAddrValid(badAddrValid), .badAddrAck(badAddrAck),
        .cpu_irq(cpu_irq), .cpu_buserror(cpu_buserror),
        .bus_burstcount(bus_burstcount), .bus_writedata(bus_writedata),
        .bus_address(bus_address), .bus_write(bus_write), .bus_read(bus_read),
        .bus_byteenable(bus_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .s_writeresponsevalid(s_writeresponsevalid), .s_response(s_response)
    );

    typedef struct {
        bit          wr;
        logic [3:0]  off;
        logic [31:0] wd;
        logic [4:0]  bc;
        logic [1:0]  er;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // One bus access; returns the registered response, bounded wait
    task automatic acc(input bit wr, input logic [3:0] off, input logic [31:0] wd,
                       input logic [4:0] bc, output logic [31:0] rd, output logic [1:0] rsp);
        int n;
        @(posedge clk); #1;
        bus_address    = BASE | 30'(off);
        bus_read       = !wr;
        bus_write      = wr;
        bus_writedata  = wd;
        bus_burstcount = bc;
        @(posedge clk); #1;
        bus_read = 1'b0; bus_write = 1'b0; bus_burstcount = 5'd1;
        n = 0;
        while (!(wr ? s_writeresponsevalid : s_readdatavalid) && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 4) begin
            checks++; errors++;
            $display("FAIL timeout: no response for offset 0x%0h got none expected strobe", off);
        end
        rd  = s_readdata;
        rsp = s_response;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] d; logic [1:0] r;
        acc(1'b0, off, 32'h0, 5'd1, d, r);
        chk({nm, " data"}, d, exp);
        chk({nm, " resp"}, 32'(r), 32'h0);
    endtask

    task automatic wr_ok(input logic [3:0] off, input logic [31:0] wd);
        logic [31:0] d; logic [1:0] r;
        acc(1'b1, off, wd, 5'd1, d, r);
        chk("write resp", 32'(r), 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        tbl[0]  = '{1'b0, 4'h0, 32'h0,   5'd1, 2'b00, 32'h0};
        tbl[1]  = '{1'b1, 4'h0, 32'hA5,  5'd1, 2'b00, 32'h0};
        tbl[2]  = '{1'b0, 4'h0, 32'h0,   5'd1, 2'b00, 32'hA5};
        tbl[3]  = '{1'b0, 4'h2, 32'h0,   5'd1, 2'b11, 32'h0};
        tbl[4]  = '{1'b1, 4'h6, 32'h1,   5'd1, 2'b11, 32'h0};
        tbl[5]  = '{1'b1, 4'h0, 32'hFF,  5'd2, 2'b11, 32'h0};
        tbl[6]  = '{1'b0, 4'h0, 32'h0,   5'd1, 2'b00, 32'hA5};
        tbl[7]  = '{1'b0, 4'h0, 32'h0,   5'd0, 2'b11, 32'h0};
        tbl[8]  = '{1'b1, 4'hD, 32'd200, 5'd1, 2'b00, 32'h0};
        tbl[9]  = '{1'b0, 4'hD, 32'h0,   5'd1, 2'b00, 32'd64};
        tbl[10] = '{1'b1, 4'hD, 32'd10,  5'd1, 2'b00, 32'h0};
        tbl[11] = '{1'b0, 4'hD, 32'h0,   5'd1, 2'b00, 32'd10};
        tbl[12] = '{1'b1, 4'hF, 32'h0,   5'd1, 2'b11, 32'h0};
        tbl[13] = '{1'b0, 4'hF, 32'h0,   5'd1, 2'b00, 32'h0};
        tbl[14] = '{1'b1, 4'hD, 32'd64,  5'd1, 2'b00, 32'h0};
        tbl[15] = '{1'b1, 4'h0, 32'h0,   5'd1, 2'b00, 32'h0};
        tbl[16] = '{1'b0, 4'h9, 32'h0,   5'd1, 2'b00, 32'h0};
        tbl[17] = '{1'b0, 4'hB, 32'h0,   5'd1, 2'b11, 32'h0};

        // Reset state
        idle(3);
        chk("reset cpu_irq", 32'(cpu_irq), 32'h0);
        chk("reset buserror", 32'(cpu_buserror), 32'h0);
        chk("reset ack", 32'(badAddrAck), 32'h0);
        chk("reset rvalid", 32'(s_readdatavalid), 32'h0);
        chk("reset waitrequest", 32'(s_waitrequest), 32'h0);
        rst = 1'b0;
        rd_chk("reset ipl", 4'hD, 32'd64);

        // Register map vectors
        for (int i = 0; i < 18; i++) begin
            acc(tbl[i].wr, tbl[i].off, tbl[i].wd, tbl[i].bc, d, r);
            chk($sformatf("vec[%0d] resp", i), 32'(r), 32'(tbl[i].er));
            chk($sformatf("vec[%0d] data", i), d, tbl[i].ed);
        end

        // Address outside the window: no response at all
        @(posedge clk); #1;
        bus_address = BASE + 30'h10; bus_read = 1'b1;
        @(posedge clk); #1;
        bus_read = 1'b0;
        chk("miss no rvalid", 32'(s_readdatavalid), 32'h0);

        // Level source 5: two-cycle latency, claim, then retire
        @(posedge clk); #1;
        irqs[5] = 1'b1;
        @(posedge clk); #1;
        chk("lvl5 cycle1 irq", 32'(cpu_irq), 32'h0);
        @(posedge clk); #1;
        chk("lvl5 cycle2 irq", 32'(cpu_irq), 32'h1);
        irqs[5] = 1'b0;
        rd_chk("lvl5 claim", 4'hC, 32'h80000005);
        chk("lvl5 irq after claim", 32'(cpu_irq), 32'h1);
        @(posedge clk); #1;
        chk("lvl5 irq dropped", 32'(cpu_irq), 32'h0);
        rd_chk("lvl5 pend0", 4'h4, 32'h0);

        // Edge source 40: pulse latches until completed by CLAIM write
        wr_ok(4'h9, 32'h00000100);
        @(posedge clk); #1;
        irqs[40] = 1'b1;
        @(posedge clk); #1;
        irqs[40] = 1'b0;
        idle(2);
        rd_chk("edge40 pend1", 4'h5, 32'h00000100);
        idle(3);
        rd_chk("edge40 pend1 held", 4'h5, 32'h00000100);
        chk("edge40 irq", 32'(cpu_irq), 32'h1);
        wr_ok(4'hC, 32'd40);
        rd_chk("edge40 completed", 4'h5, 32'h0);

        // Threshold and disable interplay with sources 3 and 9
        wr_ok(4'h4, 32'h00000208);
        wr_ok(4'hD, 32'd4);
        idle(2);
        rd_chk("ipl4 claim", 4'hC, 32'h80000003);
        wr_ok(4'h4, 32'h00000008);
        wr_ok(4'h0, 32'h00000008);
        idle(2);
        chk("disa3 irq", 32'(cpu_irq), 32'h0);
        rd_chk("disa3 claim empty", 4'hC, 32'h0);
        wr_ok(4'hD, 32'd10);
        idle(2);
        rd_chk("ipl10 claim", 4'hC, 32'h80000009);
        wr_ok(4'h4, 32'h00000200);
        idle(2);
        chk("ipl10 irq", 32'(cpu_irq), 32'h1);
        wr_ok(4'hD, 32'd0);
        idle(2);
        chk("ipl0 irq", 32'(cpu_irq), 32'h0);
        wr_ok(4'h4, 32'h0);
        wr_ok(4'h0, 32'h0);
        wr_ok(4'hD, 32'd64);

        // Level set beats claim-read clear in the same cycle
        @(posedge clk); #1;
        irqs[7] = 1'b1;
        idle(3);
        rd_chk("lvl7 claim", 4'hC, 32'h80000007);
        rd_chk("lvl7 pend kept", 4'h4, 32'h00000080);
        irqs[7] = 1'b0;
        rd_chk("lvl7 claim again", 4'hC, 32'h80000007);
        rd_chk("lvl7 pend cleared", 4'h4, 32'h0);

        // Bad-address capture, ack and clearing read
        @(posedge clk); #1;
        badAddr = 32'hDEADBEEF; badAddrValid = 1'b1;
        @(posedge clk); #1;
        badAddrValid = 1'b0;
        chk("bad ack", 32'(badAddrAck), 32'h1);
        chk("bad buserror", 32'(cpu_buserror), 32'h1);
        @(posedge clk); #1;
        chk("bad ack one cycle", 32'(badAddrAck), 32'h0);
        rd_chk("bad read", 4'hE, 32'hDEADBEEF);
        chk("bad cleared", 32'(cpu_buserror), 32'h0);

        // Capture coinciding with clearing read: old value read, new kept
        @(posedge clk); #1;
        badAddr = 32'h00001234; badAddrValid = 1'b1;
        @(posedge clk); #1;
        badAddrValid = 1'b0;
        @(posedge clk); #1;
        bus_address = BASE | 30'hE; bus_read = 1'b1;
        badAddr = 32'h00005678; badAddrValid = 1'b1;
        @(posedge clk); #1;
        bus_read = 1'b0; badAddrValid = 1'b0;
        chk("bad race old data", s_readdata, 32'h00001234);
        chk("bad race buserror", 32'(cpu_buserror), 32'h1);
        rd_chk("bad race new", 4'hE, 32'h00005678);

        // Reset with pending source, latched error and access in flight
        wr_ok(4'hD, 32'd20);
        @(posedge clk); #1;
        irqs[5] = 1'b1;
        badAddr = 32'hCAFE0000; badAddrValid = 1'b1;
        @(posedge clk); #1;
        badAddrValid = 1'b0;
        idle(2);
        chk("pre-reset irq", 32'(cpu_irq), 32'h1);
        rst = 1'b1;
        bus_address = BASE | 30'hF; bus_read = 1'b1;
        @(posedge clk); #1;
        bus_read = 1'b0; irqs = '0;
        chk("rst irq", 32'(cpu_irq), 32'h0);
        chk("rst buserror", 32'(cpu_buserror), 32'h0);
        chk("rst ack", 32'(badAddrAck), 32'h0);
        chk("rst rvalid", 32'(s_readdatavalid), 32'h0);
        chk("rst wvalid", 32'(s_writeresponsevalid), 32'h0);
        chk("rst rdata", s_readdata, 32'h0);
        chk("rst resp", 32'(s_response), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_chk("rst ipl", 4'hD, 32'd64);
        rd_chk("rst pend0", 4'h4, 32'h0);
        rd_chk("rst edge1", 4'h9, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsic_n.md
Name: lsic_n

Overview:
- Parametrised successor to the single-bank LSIC: Avalon-MM slave interrupt controller for NUM_IRQS sources (32..128, multiple of 32).
- Adds per-source edge/level mode, a read-to-claim / write-to-complete handshake, and a generic IPL threshold.
- Keeps the bus-error (bad address) latch.
- Sits between peripheral IRQ lines and the CPU irq/buserror inputs.

Parameters:
- NUM_IRQS, 64, number of sources; multiple of 32, max 128; W = NUM_IRQS/32 words per bank.
- BASE_WORD, 30'h3E00C000, word address of the block; 16-word window, bits [3:0] must be 0.
- IDW, $clog2(NUM_IRQS), ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- irqs  in  NUM_IRQS  source lines, synchronous to clk
- badAddr  in  32  faulting address
- badAddrValid  in  1  capture strobe
- badAddrAck  out  1  one-cycle ack of capture
- cpu_irq  out  1  interrupt request to CPU
- cpu_buserror  out  1  bad address latched
- bus_burstcount  in  5  Avalon burstcount
- bus_writedata  in  32  write data
- bus_address  in  30  word address
- bus_write  in  1  write
- bus_read  in  1  read
- bus_byteenable  in  4  ignored; full-word access only
- s_waitrequest  out  1  tied 0
- s_readdata  out  32  read data
- s_readdatavalid  out  1  read response strobe
- s_writeresponsevalid  out  1  write response strobe
- s_response  out  2  00 OKAY, 11 DECODEERROR

Behaviour:
- Decode: hit = bus_address[29:4] == BASE_WORD[29:4] and (bus_read or bus_write). Offset is bus_address[3:0]. Read wins if both strobes are set.
- Register map (offset: content):
  - 0x0..0x3: DISA[w]
  - 0x4..0x7: PEND[w]
  - 0x8..0xB: EDGE[w] (1 = edge mode)
  - 0xC: CLAIM
  - 0xD: IPL
  - 0xE: BADADDR
  - 0xF: STATUS = {cpu_irq, cpu_buserror, 30'h0}, read-only.
  - Bank word index w >= W -> DECODEERROR.
- Response: every hit produces s_readdatavalid (read) or s_writeresponsevalid (write) exactly 1 cycle later, with registered s_readdata/s_response. Error cases:
  - bus_burstcount != 1 -> DECODEERROR, no side effects.
  - Unmapped offset -> DECODEERROR, no side effects.
  - Write to STATUS -> DECODEERROR.
  - On any error, readdata = 0.
- Pending update each cycle, in order:
  1. Clear term: PEND write with data 0 clears that word; nonzero data ORs in (software trigger). CLAIM read clears the claimed bit. CLAIM write clears bit writedata[IDW-1:0].
  2. Set term: level sources set while irqs[i] = 1; edge sources set on irqs[i] & ~irqs_q[i], where irqs_q is a 1-cycle delayed copy.
  - Set wins over clear in the same cycle.
- Eligible: pend & ~disa & (i < ipl_r).
  - ipl_r is IDW+1 bits; reset value NUM_IRQS (all allowed); 0 masks all sources.
  - IPL writes above NUM_IRQS saturate to NUM_IRQS.
- Resolution: lowest eligible index wins. claim_q = {valid, id} is registered once.
  - cpu_irq = claim_q.valid.
  - Latency: irqs edge -> pend_r at cycle 1 -> cpu_irq at cycle 2.
- CLAIM read returns {claim_q.valid, 31-IDW zeros, claim_q.id}. If valid, the same cycle clears that pending bit. If not valid, it returns 0 with OKAY.
- Bad address:
  - badAddrValid -> bad_r = {1, badAddr}, badAddrAck = 1 for one cycle.
  - BADADDR read returns bad_r[31:0] and clears bad_r.
  - Capture and clearing read in the same cycle: the read returns the old value; the new capture wins.
  - cpu_buserror = bad_r[32].
- Reset (synchronous, rst = 1): DISA = 0, PEND = 0, EDGE = 0, irqs_q = 0, ipl_r = NUM_IRQS, claim_q = 0, bad_r = 0. All outputs are 0.
  - Reset overrides any in-flight access; no response is issued for it.

Decomposition:
- lsic_pkg holds:
  - Offset constants OFF_DISA, OFF_PEND, OFF_EDGE, OFF_CLAIM, OFF_IPL, OFF_BAD, OFF_STATUS.
  - RESP_OKAY / RESP_DECERR.
  - typedef claim_t {valid, id}.
- Sub-module lsic_prio_enc (parameter N): combinational lowest-index-first encoder, outputs {valid, id}.

Test Plan:
- Level source 5: irqs[5] held high -> cpu_irq at cycle 2. CLAIM read returns 0x80000005. irqs[5] dropped before the read -> PEND bit cleared, cpu_irq low 2 cycles later.
- Edge source 40 (EDGE[1] bit 8 = 1): single-cycle pulse -> PEND[1] = 0x00000100, held until a CLAIM write of 40 -> PEND[1] = 0.
- Sources 3 and 9 pending, IPL = 4 -> claim id 3. DISA[0] = 0x8 -> no claim. IPL = 10 -> claim id 9. IPL = 0 -> cpu_irq low.
- Simultaneous level irqs[7] high and CLAIM read of id 7 -> read returns 0x80000007, PEND bit 7 remains 1.
- badAddrValid with 0xDEADBEEF -> badAddrAck one cycle, cpu_buserror = 1. BADADDR read -> 0xDEADBEEF, then cpu_buserror = 0.
- Errors with NUM_IRQS = 64: read offset 0x2 -> response 11, readdata 0. burstcount = 2 write to DISA -> response 11, DISA unchanged. rst mid-pending -> all outputs 0, ipl = 64.
